// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, FSM state types and the per-beat address helper
// used by the RAM slave and its bank.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } burst_cmd_t;

    // WRAP and the reserved code step like INCR; sizes above 4 bytes step by 4.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] step;
        step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + step;
            default:     next_addr = addr + step;
        endcase
    endfunction

    function automatic logic burst_err(input logic [1:0] burst);
        return (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI3 read/write channel bundle between a master and the RAM slave.
interface axi_ram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/axi_ram_bank.sv
// Word RAM with a registered read port and a byte-enabled write port,
// shaped so synthesis maps it onto block RAM.
module axi_ram_bank #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [31:0]           rd_data,
    input  logic [3:0]            wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [31:0]           wr_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // NOTE: the array itself is never reset so it stays inferable as block RAM;
    // only the output register is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Same-cycle read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (!resetn)    rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by an internal byte-writable RAM; independent read and
// write engines, one outstanding burst each.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int READ_DELAY = 0
) (
    input logic             clk,
    input logic             resetn,
    axi_ram_slave_if.slave  bus
);

    localparam logic [3:0] DLY_LAST = 4'(READ_DELAY - 1);

    rd_state_t  r_state, r_next;
    wr_state_t  w_state, w_next;
    burst_cmd_t r_cmd, w_cmd;
    logic [7:0] r_cnt, w_cnt;
    logic [3:0] r_dly;
    logic       w_err;
    logic       ready_en;
    logic       ar_hs, r_hs, aw_hs, w_hs, r_last, w_last;
    logic [31:0] r_addr_nxt;
    logic       unused_wid;

    assign unused_wid = ^bus.wid;

    // Holds arready/awready low for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!resetn) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    assign ar_hs  = bus.arvalid && bus.arready;
    assign r_hs   = bus.rvalid && bus.rready;
    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign r_last = (r_cnt == r_cmd.len);
    assign w_last = (w_cnt == w_cmd.len);

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        r_next      = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                bus.arready = ready_en;
                if (bus.arvalid && ready_en) r_next = (READ_DELAY == 0) ? R_BURST : R_WAIT;
            end
            R_WAIT:  if (r_dly == DLY_LAST) r_next = R_BURST;
            R_BURST: begin
                bus.rvalid = 1'b1;
                if (bus.rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next      = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = ready_en;
                if (bus.awvalid && ready_en) w_next = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign r_addr_nxt = next_addr(r_cmd.addr, r_cmd.size, r_cmd.burst);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cmd <= '0;
            r_cnt <= '0;
            r_dly <= '0;
        end else if (ar_hs) begin
            r_cmd <= '{id: bus.arid, addr: bus.araddr, len: bus.arlen,
                       size: bus.arsize, burst: bus.arburst};
            r_cnt <= '0;
            r_dly <= '0;
        end else begin
            if (r_state == R_WAIT) r_dly <= r_dly + 4'd1;
            if (r_hs) begin
                r_cmd.addr <= r_addr_nxt;
                r_cnt      <= r_cnt + 8'd1;
            end
        end
    end

    // A protocol error is any beat whose wlast disagrees with the beat count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_cmd <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_cmd <= '{id: bus.awid, addr: bus.awaddr, len: bus.awlen,
                       size: bus.awsize, burst: bus.awburst};
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (w_hs) begin
            w_cmd.addr <= next_addr(w_cmd.addr, w_cmd.size, w_cmd.burst);
            w_cnt      <= w_cnt + 8'd1;
            if (bus.wlast != w_last) w_err <= 1'b1;
        end
    end

    assign bus.rid   = r_cmd.id;
    assign bus.rresp = burst_err(r_cmd.burst) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rlast = bus.rvalid && r_last;
    assign bus.bid   = w_cmd.id;
    assign bus.bresp = (w_err || burst_err(w_cmd.burst)) ? RESP_SLVERR : RESP_OKAY;

    axi_ram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
        .clk     (clk),
        .resetn  (resetn),
        .rd_en   (ar_hs || (r_hs && !r_last)),
        .rd_idx  (ar_hs ? bus.araddr[ADDR_WIDTH+1:2] : r_addr_nxt[ADDR_WIDTH+1:2]),
        .rd_data (bus.rdata),
        .wr_be   (w_hs ? bus.wstrb : 4'b0000),
        .wr_idx  (w_cmd.addr[ADDR_WIDTH+1:2]),
        .wr_data (bus.wdata)
    );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a word-array reference model produces
// expected R/B responses; independent monitors compare what the DUT returns.
module tb_axi_ram_slave;

    localparam int AW = 12;
    localparam int RD = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_ram_slave_if bus ();

    axi_ram_slave #(.ADDR_WIDTH(AW), .READ_DELAY(RD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;

    logic [31:0] model [1 << AW];
    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    logic        wq_last[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int r_beats = 0;
    logic rr_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Reference rules: word = byte address / 4 modulo RAM size; FIXED stays,
    // everything else steps by the (capped) beat size.
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(1 << AW));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                              input logic [2:0] size, input logic [1:0] burst);
        int step;
        step = (size > 3'd2) ? 4 : (1 << size);
        return (burst == 2'b00) ? a : a + 32'(k * step);
    endfunction

    task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        for (int k = 0; k <= int'(len); k++)
            r_q.push_back('{id: id, data: model[widx(beat_addr(addr, k, size, burst))],
                            resp: (burst >= 2'b10) ? 2'b10 : 2'b00, last: (k == int'(len))});
    endtask

    task automatic wclear();
        wq_data.delete();
        wq_strb.delete();
        wq_last.delete();
    endtask

    task automatic wpush(input logic [31:0] d, input logic [3:0] s, input logic l);
        wq_data.push_back(d);
        wq_strb.push_back(s);
        wq_last.push_back(l);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        @(negedge clk);
        while (!bus.arready && n < 200) begin @(negedge clk); n++; end
        if (!bus.arready) fail_timeout("ar_handshake");
        hs_cyc = cyc;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Applies the queued beats to the model, predicts B, then drives AW and W.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
        logic err;
        int   n, idx;
        err = (burst >= 2'b10);
        for (int k = 0; k <= int'(len); k++) begin
            idx = widx(beat_addr(addr, k, size, burst));
            for (int b = 0; b < 4; b++)
                if (wq_strb[k][b]) model[idx][8*b +: 8] = wq_data[k][8*b +: 8];
            if (wq_last[k] != (k == int'(len))) err = 1'b1;
        end
        b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 200) begin @(negedge clk); n++; end
        if (!bus.awready) fail_timeout("aw_handshake");
        hs_cyc = cyc;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            bus.wid = id; bus.wdata = wq_data[k]; bus.wstrb = wq_strb[k]; bus.wlast = wq_last[k];
            bus.wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < 200) begin @(negedge clk); n++; end
            if (!bus.wready) fail_timeout("w_handshake");
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 600) begin @(negedge clk); n++; end
        if (r_q.size() != 0 || b_q.size() != 0) begin
            fail_timeout("drain_responses");
            r_q.delete();
            b_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Issues a read, returns AR-to-first-rvalid latency and first-to-last beat span.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           output int lat, output int span);
        int hs, first, n;
        expect_read(id, addr, len, size, burst);
        do_ar(id, addr, len, size, burst, hs);
        n = 0;
        @(negedge clk);
        while (!bus.rvalid && n < 100) begin @(negedge clk); n++; end
        if (!bus.rvalid) fail_timeout("first_rvalid");
        first = cyc;
        lat = first - hs;
        while (!(bus.rvalid && bus.rready && bus.rlast) && n < 600) begin @(negedge clk); n++; end
        span = cyc - first;
        wait_idle();
    endtask

    // R monitor: scoreboard compare on each handshake, stability check on stalls.
    logic        held = 1'b0;
    logic [31:0] h_data;
    logic [3:0]  h_id;
    logic [1:0]  h_resp;
    logic        h_last;
    always @(negedge clk) begin
        r_exp_t e;
        if (resetn && bus.rvalid) begin
            if (held) begin
                check("r_stall_data", bus.rdata, h_data);
                check("r_stall_last", 32'(bus.rlast), 32'(h_last));
                check("r_stall_id", 32'(bus.rid), 32'(h_id));
                check("r_stall_resp", 32'(bus.rresp), 32'(h_resp));
            end
            if (bus.rready) begin
                held = 1'b0;
                r_beats++;
                if (r_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got beat %h with no read outstanding", bus.rdata);
                end else begin
                    e = r_q.pop_front();
                    check("r_data", bus.rdata, e.data);
                    check("r_id", 32'(bus.rid), 32'(e.id));
                    check("r_resp", 32'(bus.rresp), 32'(e.resp));
                    check("r_last", 32'(bus.rlast), 32'(e.last));
                end
            end else begin
                held = 1'b1;
                h_data = bus.rdata; h_id = bus.rid; h_resp = bus.rresp; h_last = bus.rlast;
            end
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge clk) begin
        b_exp_t e;
        if (resetn && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got bid %h with no write outstanding", bus.bid);
            end else begin
                e = b_q.pop_front();
                check("b_id", 32'(bus.bid), 32'(e.id));
                check("b_resp", 32'(bus.bresp), 32'(e.resp));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rr_rand) begin
                bus.rready = 1'($urandom % 2);
                bus.bready = 1'($urandom % 2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2, lat, span, base, n;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rlast", 32'(bus.rlast), 0);
        check("rst_rid", 32'(bus.rid), 0);
        check("rst_bid", 32'(bus.bid), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", 32'(bus.rresp), 0);
        check("rst_bresp", 32'(bus.bresp), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_arready", 32'(bus.arready), 0);
        check("post_rst_awready", 32'(bus.awready), 0);
        @(negedge clk);
        check("post_rst_arready_up", 32'(bus.arready), 1);
        check("post_rst_awready_up", 32'(bus.awready), 1);
        @(posedge clk); #1;

        // Fill the whole RAM so every later read has a defined expectation.
        for (int blk = 0; blk < 16; blk++) begin
            wclear();
            for (int k = 0; k < 256; k++) wpush($urandom, 4'hF, k == 255);
            do_write(4'(blk), 32'(blk * 1024), 8'd255, 3'd2, 2'b01, hs);
            wait_idle();
        end

        // INCR write then back-to-back read.
        wclear();
        wpush(32'h11111111, 4'hF, 0); wpush(32'h22222222, 4'hF, 0);
        wpush(32'h33333333, 4'hF, 0); wpush(32'h44444444, 4'hF, 1);
        do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, hs);
        wait_idle();
        do_read(4'd0, 32'h100, 8'd3, 3'd2, 2'b01, lat, span);
        check("incr_latency", 32'(lat), 32'(1 + RD));
        check("incr_back_to_back", 32'(span), 3);

        // Byte strobes.
        wclear(); wpush(32'hAABBCCDD, 4'hF, 1);
        do_write(4'd2, 32'h200, 8'd0, 3'd2, 2'b01, hs);
        wait_idle();
        wclear(); wpush(32'h11223344, 4'b0101, 1);
        do_write(4'd3, 32'h200, 8'd0, 3'd2, 2'b01, hs);
        wait_idle();
        do_read(4'd4, 32'h200, 8'd0, 3'd2, 2'b01, lat, span);

        // R backpressure: rready 1,0,0,1 across the first beats.
        expect_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
        do_ar(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, hs);
        n = 0;
        @(negedge clk);
        while (!bus.rvalid && n < 100) begin @(negedge clk); n++; end
        if (!bus.rvalid) fail_timeout("bp_first_rvalid");
        check("bp_latency", 32'(cyc - hs), 32'(1 + RD));
        @(posedge clk); #1; bus.rready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus.rready = 1'b1;
        wait_idle();

        // Concurrent AR and AW to the same word.
        wclear(); wpush(32'h0, 4'hF, 1);
        do_write(4'd6, 32'h300, 8'd0, 3'd2, 2'b01, hs);
        wait_idle();
        expect_read(4'd7, 32'h300, 8'd0, 3'd2, 2'b01);
        wclear(); wpush(32'hDEADBEEF, 4'hF, 1);
        fork
            do_ar(4'd7, 32'h300, 8'd0, 3'd2, 2'b01, hs);
            do_write(4'd8, 32'h300, 8'd0, 3'd2, 2'b01, hs2);
        join
        check("same_cycle_ar_aw", 32'(hs2), 32'(hs));
        wait_idle();
        do_read(4'd9, 32'h300, 8'd0, 3'd2, 2'b01, lat, span);

        // FIXED burst, early wlast, WRAP read.
        wclear();
        for (int k = 0; k < 4; k++) wpush(32'(k + 1), 4'hF, k == 3);
        do_write(4'd10, 32'h400, 8'd3, 3'd2, 2'b00, hs);
        wait_idle();
        do_read(4'd11, 32'h400, 8'd0, 3'd2, 2'b01, lat, span);
        wclear(); wpush(32'hA0A0A0A0, 4'hF, 1); wpush(32'hA1A1A1A1, 4'hF, 0);
        do_write(4'd12, 32'h500, 8'd1, 3'd2, 2'b01, hs);
        wait_idle();
        do_read(4'd13, 32'h500, 8'd1, 3'd2, 2'b01, lat, span);
        do_read(4'd14, 32'h100, 8'd3, 3'd2, 2'b10, lat, span);

        // Reset during beat 2 of a 4-beat read.
        expect_read(4'd15, 32'h100, 8'd3, 3'd2, 2'b01);
        do_ar(4'd15, 32'h100, 8'd3, 3'd2, 2'b01, hs);
        base = r_beats - 1;
        base = base + 1;
        n = 0;
        while (r_beats < base + 2 && n < 100) begin @(posedge clk); #2; n++; end
        if (r_beats < base + 2) fail_timeout("reset_beats");
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        r_q.delete();
        @(negedge clk);
        check("rst_mid_rvalid", 32'(bus.rvalid), 0);
        check("rst_mid_arready_low", 32'(bus.arready), 0);
        @(negedge clk);
        check("rst_mid_arready_up", 32'(bus.arready), 1);
        @(posedge clk); #1;
        do_read(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, lat, span);
        check("rst_mid_new_latency", 32'(lat), 32'(1 + RD));

        // Randomized bursts with random backpressure.
        rr_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            a = $urandom;
            len = 8'($urandom_range(0, 7));
            size = 3'($urandom_range(0, 4));
            burst = 2'($urandom_range(0, 3));
            wclear();
            for (int k = 0; k <= int'(len); k++)
                wpush($urandom, 4'($urandom), (k == int'(len)) ^ (($urandom % 8) == 0));
            do_write(4'($urandom), a, len, size, burst, hs);
            wait_idle();
            do_read(4'($urandom), a, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
                    2'($urandom_range(0, 3)), lat, span);
            check("rand_latency", 32'(lat), 32'(1 + RD));
        end
        rr_rand = 1'b0;
        @(posedge clk); #1;
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
